// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: initial hash value, engine state encoding and the
// FIPS 180-4 bit functions used by the round logic and the message schedule.
package sha256_pkg;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } sha_state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, f, g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: 16-word shift register, W[0] is the word consumed
// by the current round and the newly expanded word enters at W[15].
module sha256_msg_sched
    import sha256_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_shift,
    input  logic [511:0] i_block,
    output logic [31:0]  o_w0
);

    logic [31:0] w_q [16];
    logic [31:0] w_new;

    assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    assign o_w0  = w_q[0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else if (i_load) begin
            for (int i = 0; i < 16; i++) w_q[i] <= i_block[511-32*i -: 32];
        end else if (i_shift) begin
            for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
            w_q[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression, one round per clock, K supplied externally.
// Define SHA256_CHAIN_EN to add i_first and chain multi-block messages from o_digest.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [511:0] i_block,
`ifdef SHA256_CHAIN_EN
    input  logic         i_first,
`endif
    output logic [5:0]   o_coef_num,
    input  logic [31:0]  i_coef_value,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [255:0] o_digest,
    output logic [1:0]   o_dbg_state
);

    // Input side: block accepted on i_valid && o_ready. Output side: digest
    // held with o_valid until an edge with i_ready high retires it.
    sha_state_t   state_q;
    logic [5:0]   cnt_q;
    logic         valid_q;
    logic [255:0] digest_q;
    logic [31:0]  v_q [8];
    logic [31:0]  v_d [8];
    logic [31:0]  h_init_q [8];
    logic [31:0]  h_init_d [8];
    logic [255:0] digest_d;
    logic [255:0] init_src;
    logic [31:0]  w0;
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic         accept;

    assign o_ready     = (state_q == ST_IDLE);
    assign accept      = i_valid && o_ready;
    assign o_coef_num  = (state_q == ST_ROUND) ? cnt_q : 6'd0;
    assign o_valid     = valid_q;
    assign o_digest    = digest_q;
    assign o_dbg_state = state_q;

`ifdef SHA256_CHAIN_EN
    assign init_src = i_first ? SHA256_IV : digest_q;
`else
    assign init_src = SHA256_IV;
`endif

    sha256_msg_sched u_sched (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (accept),
        .i_shift (state_q == ST_ROUND),
        .i_block (i_block),
        .o_w0    (w0)
    );

    // v_q[0..7] hold a..h
    always_comb begin
        t1 = v_q[7] + big_sigma1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + i_coef_value + w0;
        t2 = big_sigma0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
        v_d[0] = t1 + t2;
        v_d[1] = v_q[0];
        v_d[2] = v_q[1];
        v_d[3] = v_q[2];
        v_d[4] = v_q[3] + t1;
        v_d[5] = v_q[4];
        v_d[6] = v_q[5];
        v_d[7] = v_q[6];
        digest_d = '0;
        for (int i = 0; i < 8; i++) begin
            h_init_d[i] = init_src[255-32*i -: 32];
            digest_d[255-32*i -: 32] = h_init_q[i] + v_q[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            digest_q <= '0;
            for (int i = 0; i < 8; i++) begin
                v_q[i]      <= '0;
                h_init_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        v_q      <= h_init_d;
                        h_init_q <= h_init_d;
                        cnt_q    <= '0;
                        state_q  <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    v_q   <= v_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) state_q <= ST_FINAL;
                end
                ST_FINAL: begin
                    digest_q <= digest_d;
                    valid_q  <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known vectors, random blocks against
// an array-based reference, back-pressure, round-index trace and mid-run reset.
module tb_sha256_compress;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [511:0] i_block;
    logic         i_first;
    logic [5:0]   o_coef_num;
    logic [31:0]  i_coef_value;
    logic         o_valid;
    logic         i_ready;
    logic [255:0] o_digest;
    logic [1:0]   o_dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [255:0] exp_q[$];

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Stands in for the sha256_coefs table
    assign i_coef_value = k_tab[o_coef_num];

    sha256_compress dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_block      (i_block),
`ifdef SHA256_CHAIN_EN
        .i_first      (i_first),
`endif
        .o_coef_num   (o_coef_num),
        .i_coef_value (i_coef_value),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_digest     (o_digest),
        .o_dbg_state  (o_dbg_state)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] s [8];
        logic [31:0] t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = s[7] + (ror(s[4], 6) ^ ror(s[4], 11) ^ ror(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k_tab[t] + w[t];
            t2 = (ror(s[0], 2) ^ ror(s[0], 13) ^ ror(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            for (int i = 7; i > 0; i--) s[i] = s[i-1];
            s[4] = s[4] + t1;
            s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + s[i];
        return res;
    endfunction

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int cycles);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (cycles) @(posedge i_clk);
        #1;
        check_val("rst_ready", 256'(o_ready), 256'd1);
        check_val("rst_valid", 256'(o_valid), 256'd0);
        check_val("rst_coef", 256'(o_coef_num), 256'd0);
        check_val("rst_digest", o_digest, 256'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    // Sends a block and waits for the digest; leaves the engine in DONE.
    task automatic send_block(input string tag, input logic [511:0] blk, input logic first);
        int edges;
        int wait_cyc;
        bit trace_ok;
        logic [255:0] exp;
        wait_cyc = 0;
        @(negedge i_clk);
        while (!o_ready && wait_cyc < 200) begin
            @(negedge i_clk);
            wait_cyc++;
        end
        check_val({tag, "_ready"}, 256'(o_ready), 256'd1);
        i_valid = 1'b1;
        i_block = blk;
        i_first = first;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_block = {16{$urandom}};
        edges = 0;
        trace_ok = 1'b1;
        while (!o_valid && edges < 100) begin
            if (edges < 64 && o_coef_num != 6'(edges)) trace_ok = 1'b0;
            if (edges == 64 && o_coef_num != 6'd0) trace_ok = 1'b0;
            if (edges < 60) i_ready = 1'($urandom_range(0, 1));
            else i_ready = 1'b0;
            @(posedge i_clk);
            #1;
            edges++;
        end
        check_val({tag, "_latency"}, 256'(edges), 256'd65);
        check_val({tag, "_coef_trace"}, 256'(trace_ok), 256'd1);
        check_val({tag, "_done_coef"}, 256'(o_coef_num), 256'd0);
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 256'd0, 256'd1);
        end else begin
            exp = exp_q.pop_front();
            check_val({tag, "_digest"}, o_digest, exp);
        end
    endtask

    task automatic release_digest(input string tag);
        @(negedge i_clk);
        i_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check_val({tag, "_rel_valid"}, 256'(o_valid), 256'd0);
        check_val({tag, "_rel_ready"}, 256'(o_ready), 256'd1);
        i_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    localparam logic [511:0] BLK_ABC   = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    initial begin
        logic [511:0] blk;
        logic [255:0] held;
        int wait_cyc;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_block = '0;
        i_first = 1'b1;
        i_ready = 1'b0;
        do_reset(3);

        exp_q.push_back(DIG_ABC);
        send_block("abc", BLK_ABC, 1'b1);
        release_digest("abc");

        exp_q.push_back(DIG_EMPTY);
        send_block("empty", BLK_EMPTY, 1'b1);

        // Back-pressure: hold DONE while a new block is offered
        held = o_digest;
        blk = {16{$urandom}};
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            i_valid = 1'b1;
            i_block = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge i_clk);
            #1;
            if (c == 0 || c == 9) begin
                check_val("bp_digest", o_digest, held);
                check_val("bp_ready", 256'(o_ready), 256'd0);
                check_val("bp_valid", 256'(o_valid), 256'd1);
            end
        end
        @(negedge i_clk);
        i_valid = 1'b0;
        release_digest("bp");

        for (int n = 0; n < 6; n++) begin
            blk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(ref_compress(IV, blk));
            send_block("rand", blk, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
            release_digest("rand");
        end

        // Reset at round 30
        @(negedge i_clk);
        i_valid = 1'b1;
        i_block = BLK_ABC;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        wait_cyc = 0;
        while (o_coef_num != 6'd30 && wait_cyc < 100) begin
            @(posedge i_clk);
            #1;
            wait_cyc++;
        end
        check_val("mid_coef30", 256'(o_coef_num), 256'd30);
        do_reset(1);
        exp_q.push_back(DIG_ABC);
        send_block("abc_rerun", BLK_ABC, 1'b1);
        release_digest("abc_rerun");

`ifdef SHA256_CHAIN_EN
        begin
            logic [511:0] b1;
            logic [511:0] b2;
            b1 = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                  32'h80000000, 32'h0};
            b2 = {448'h0, 64'h1c0};
            exp_q.push_back(ref_compress(IV, b1));
            send_block("chain1", b1, 1'b1);
            release_digest("chain1");
            exp_q.push_back(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
            send_block("chain2", b2, 1'b0);
            release_digest("chain2");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
